// File: rtl/keypad_adder_ctrl.sv
// Sequencing controller between the keypad scanner and a bit-serial adder:
// debounces scanner hits into key events, builds two operands, then runs the adder LSB first.
module keypad_adder_ctrl #(
    parameter int WIDTH   = 8,
    parameter int RELEASE = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [4:0]       key_code,
    output logic             sa_clr,
    output logic             sa_en,
    output logic             sa_a,
    output logic             sa_b,
    input  logic             sa_sum,
    input  logic             sa_cout,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    output logic             busy,
    output logic [1:0]       phase
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (RELEASE > 1) ? $clog2(RELEASE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
    localparam logic [CW-1:0] C_LAST = CW'(RELEASE - 1);

    typedef enum logic [2:0] {
        S_ENTRY_A,
        S_ENTRY_B,
        S_CLR,
        S_ADD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] op_a, op_b, op_a_d, op_b_d;
    logic [KW-1:0]   k;
    logic            armed;
    logic [CW-1:0]   idle_cnt;
    logic            hit, key_evt, is_enter, is_clear;
    logic [3:0]      digit;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] op,
                                                   input logic [3:0]       d);
        return (op << 4) | WIDTH'(d);
    endfunction

    assign hit      = key_valid && (key_code != 5'd0);
    assign key_evt  = hit && armed;
    assign is_enter = (key_code == 5'd16);
    assign is_clear = (key_code == 5'd12);
    assign digit    = key_code[3:0];

    // A held key keeps restarting the idle count, so it yields only one event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b1;
            idle_cnt <= '0;
        end else if (hit) begin
            armed    <= 1'b0;
            idle_cnt <= '0;
        end else if (!armed) begin
            if (idle_cnt == C_LAST) begin
                armed    <= 1'b1;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ENTRY_A;
            op_a    <= '0;
            op_b    <= '0;
        end else begin
            state_q <= state_d;
            op_a    <= op_a_d;
            op_b    <= op_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a;
        op_b_d  = op_b;
        sa_clr  = 1'b0;
        sa_en   = 1'b0;
        sa_a    = 1'b0;
        sa_b    = 1'b0;
        case (state_q)
            S_ENTRY_A: begin
                if (key_evt) begin
                    if (is_enter) begin
                        state_d = S_ENTRY_B;
                        op_b_d  = '0;
                    end else if (is_clear) begin
                        op_a_d = '0;
                        op_b_d = '0;
                    end else begin
                        op_a_d = shift_in(op_a, digit);
                    end
                end
            end
            S_ENTRY_B: begin
                if (key_evt) begin
                    if (is_enter) begin
                        state_d = S_CLR;
                    end else if (is_clear) begin
                        state_d = S_ENTRY_A;
                        op_a_d  = '0;
                        op_b_d  = '0;
                    end else begin
                        op_b_d = shift_in(op_b, digit);
                    end
                end
            end
            S_CLR: begin
                sa_clr  = 1'b1;
                state_d = S_ADD;
            end
            S_ADD: begin
                sa_en = 1'b1;
                sa_a  = op_a[k];
                sa_b  = op_b[k];
                if (k == K_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A digit here starts a fresh A, so the user can type the next sum directly.
                if (key_evt && !is_enter) begin
                    state_d = S_ENTRY_A;
                    op_b_d  = '0;
                    op_a_d  = is_clear ? '0 : WIDTH'(digit);
                end
            end
            default: begin
                state_d = S_ENTRY_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= '0;
            result <= '0;
        end else if (state_q == S_CLR) begin
            k      <= '0;
            result <= '0;
        end else if (state_q == S_ADD) begin
            k <= k + 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                if (k == KW'(i)) begin
                    result[i] <= sa_sum;
                end
            end
            if (k == K_LAST) begin
                result[WIDTH] <= sa_cout;
            end
        end
    end

    assign result_valid = (state_q == S_DONE);
    assign busy         = (state_q == S_CLR) || (state_q == S_ADD);

    always_comb begin
        phase = 2'd0;
        case (state_q)
            S_ENTRY_A: phase = 2'd0;
            S_ENTRY_B: phase = 2'd1;
            S_CLR,
            S_ADD:     phase = 2'd2;
            S_DONE:    phase = 2'd3;
            default:   phase = 2'd0;
        endcase
    end

endmodule
